// File: rtl/serial_frame_master_if.sv
// ---------------------------------------------------------------------------
// serial_frame_master_if
// UART-side handshake bundle for serial_frame_master.
//   rx_valid  one-cycle strobe, a byte has been received
//   rx_data   received byte, valid with rx_valid
//   tx_busy   UART transmitter busy
//   tx_start  one-cycle request to transmit tx_data
//   tx_data   byte to transmit, stable while tx_start is high
// master: the frame master (consumes rx, produces tx requests)
// slave:  the UART side
// ---------------------------------------------------------------------------
interface serial_frame_master_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  tx_busy,
        output tx_start,
        output tx_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output tx_busy,
        input  tx_start,
        input  tx_data
    );
endinterface

// File: rtl/serial_frame_master.sv
// ---------------------------------------------------------------------------
// serial_frame_master
// Assembles UART bytes into {address, payload} frames and shifts each frame
// out on a shared serial bus as start(0), address MSB first, payload MSB
// first, stop(1). Optionally echoes the address back over the UART after
// each frame. One frame can be assembled while the previous one shifts.
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   uart          UART handshake bundle (master modport)
//   serial_out_o  serial bus to the nodes, idles high
//   frame_busy_o  a frame is assembling, pending or being shifted/acked
//   drop_err_o    one-cycle pulse when a byte or partial frame is discarded
// ---------------------------------------------------------------------------
module serial_frame_master #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_BYTES = 1,
    parameter int unsigned TIMEOUT    = 65535,
    parameter bit          ACK_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_frame_master_if.master uart,
    output logic                  serial_out_o,
    output logic                  frame_busy_o,
    output logic                  drop_err_o
);
    localparam int unsigned PayW = 8 * DATA_BYTES;
    localparam int unsigned FrmW = ADDR_W + PayW;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StAddr  = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StStop  = 3'd4;
    localparam logic [2:0] StAck   = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [FrmW-1:0]   shift_q, shift_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic              full_q, full_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PayW-1:0]   pay_q, pay_d;
    logic [15:0]       tmo_q, tmo_d;

    logic       load, accept, overflow, expire;
    logic [2:0] byte_idx;
    logic [7:0] addr_ext;

    // The shifter drains the assembly register in the same cycle a new byte
    // may arrive, so that byte is accepted rather than dropped.
    assign load     = (state_q == StIdle) && full_q;
    assign accept   = uart.rx_valid && (!full_q || load);
    assign overflow = uart.rx_valid && full_q && !load;
    // Expiry fires on the TIMEOUT-th idle cycle; it wins over a byte arriving
    // in the same cycle, which then restarts assembly as byte 0.
    assign expire   = (byte_cnt_q != 3'd0) && !full_q && (tmo_q == 16'(TIMEOUT - 1));
    assign byte_idx = expire ? 3'd0 : byte_cnt_q;

    always_comb begin
        addr_ext              = '0;
        addr_ext[ADDR_W-1:0]  = addr_q;
    end

    // Frame assembly and inter-byte timeout
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        full_d     = full_q;
        addr_d     = addr_q;
        pay_d      = pay_q;
        tmo_d      = tmo_q;
        if (load) begin
            full_d = 1'b0;
        end
        if (accept) begin
            tmo_d = '0;
            if (byte_idx == 3'd0) begin
                addr_d = uart.rx_data[ADDR_W-1:0];
            end
            // First payload byte lands in the most significant position
            for (int k = 1; k <= DATA_BYTES; k++) begin
                if (byte_idx == 3'(k)) begin
                    pay_d[PayW-8*k +: 8] = uart.rx_data;
                end
            end
            if (byte_idx == 3'(DATA_BYTES)) begin
                full_d     = 1'b1;
                byte_cnt_d = '0;
            end else begin
                byte_cnt_d = byte_idx + 3'd1;
            end
        end else if (expire) begin
            byte_cnt_d = '0;
            tmo_d      = '0;
        end else if ((byte_cnt_q != 3'd0) && !full_q) begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // Serial shifter
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_data_d = tx_data_q;
        case (state_q)
            StIdle: begin
                if (full_q) begin
                    shift_d   = {addr_q, pay_q};
                    tx_data_d = addr_ext;
                    state_d   = StStart;
                end
            end
            StStart: begin
                state_d   = StAddr;
                bit_cnt_d = 6'(ADDR_W - 1);
            end
            StAddr: begin
                shift_d = shift_q << 1;
                if (bit_cnt_q == 6'd0) begin
                    state_d   = StData;
                    bit_cnt_d = 6'(PayW - 1);
                end else begin
                    bit_cnt_d = bit_cnt_q - 6'd1;
                end
            end
            StData: begin
                shift_d = shift_q << 1;
                if (bit_cnt_q == 6'd0) begin
                    state_d = StStop;
                end else begin
                    bit_cnt_d = bit_cnt_q - 6'd1;
                end
            end
            StStop: state_d = ACK_EN ? StAck : StIdle;
            StAck: begin
                if (!uart.tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tx_data_q  <= '0;
            byte_cnt_q <= '0;
            full_q     <= 1'b0;
            addr_q     <= '0;
            pay_q      <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_data_q  <= tx_data_d;
            byte_cnt_q <= byte_cnt_d;
            full_q     <= full_d;
            addr_q     <= addr_d;
            pay_q      <= pay_d;
            tmo_q      <= tmo_d;
        end
    end

    always_comb begin
        serial_out_o = 1'b1;
        if (state_q == StStart) begin
            serial_out_o = 1'b0;
        end else if ((state_q == StAddr) || (state_q == StData)) begin
            serial_out_o = shift_q[FrmW-1];
        end
    end

    assign uart.tx_start = (state_q == StAck) && !uart.tx_busy;
    assign uart.tx_data  = tx_data_q;
    assign frame_busy_o  = (state_q != StIdle) || full_q || (byte_cnt_q != 3'd0);
    assign drop_err_o    = overflow || expire;

endmodule

// File: tb/tb_serial_frame_master.sv
// Bench for serial_frame_master: dut_a (ADDR_W=8, 1 byte, TIMEOUT=16, ACK on)
// and dut_b (ADDR_W=4, 2 bytes, ACK off). Expected frames/acks are queued
// when bytes are driven and popped by the negedge monitor.
module tb_serial_frame_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_master_if ua ();
    serial_frame_master_if ub ();
    logic so_a, fb_a, de_a, so_b, fb_b, de_b;

    serial_frame_master #(.ADDR_W(8), .DATA_BYTES(1), .TIMEOUT(16), .ACK_EN(1'b1)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .uart         (ua),
        .serial_out_o (so_a),
        .frame_busy_o (fb_a),
        .drop_err_o   (de_a)
    );

    serial_frame_master #(.ADDR_W(4), .DATA_BYTES(2), .TIMEOUT(65535), .ACK_EN(1'b0)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .uart         (ub),
        .serial_out_o (so_b),
        .frame_busy_o (fb_b),
        .drop_err_o   (de_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Scoreboard queues
    logic [39:0] exp_frm_a[$];
    logic [39:0] exp_frm_b[$];
    logic [7:0]  exp_ack_a[$];

    // Monitor state, index 0 = dut_a, 1 = dut_b
    int          mst[2], mn[2], frames[2], start_cyc[2], stop_cyc[2], gap[2];
    int          drops[2], drop_cyc[2];
    logic [39:0] msh[2];
    int          acks_a = 0, tx_b = 0, last_tx_cyc = 0;
    logic        mon_s, mon_de;

    initial begin
        for (int d = 0; d < 2; d++) begin
            mst[d] = 0; mn[d] = 0; frames[d] = 0; start_cyc[d] = 0; stop_cyc[d] = 0;
            gap[d] = 0; drops[d] = 0; drop_cyc[d] = 0; msh[d] = '0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            mon_s  = (d == 0) ? so_a : so_b;
            mon_de = (d == 0) ? de_a : de_b;
            if (rst) begin
                mst[d] = 0;
            end else begin
                if (mon_de) begin
                    drops[d]++;
                    drop_cyc[d] = cyc;
                end
                case (mst[d])
                    0: if (!mon_s) begin
                        mst[d] = 1; mn[d] = 0; msh[d] = '0;
                        gap[d] = cyc - stop_cyc[d];
                        start_cyc[d] = cyc;
                    end
                    1: begin
                        msh[d] = {msh[d][38:0], mon_s};
                        mn[d]++;
                        if (mn[d] == ((d == 0) ? 16 : 20)) mst[d] = 2;
                    end
                    default: begin
                        chk("stop bit", longint'(mon_s), 1);
                        frames[d]++;
                        stop_cyc[d] = cyc;
                        mst[d] = 0;
                        if (d == 0) begin
                            if (exp_frm_a.size() > 0) chk("frame a bits", msh[d], exp_frm_a.pop_front());
                            else chk("frame a expected", 0, 1);
                        end else begin
                            if (exp_frm_b.size() > 0) chk("frame b bits", msh[d], exp_frm_b.pop_front());
                            else chk("frame b expected", 0, 1);
                        end
                    end
                endcase
            end
        end
        if (!rst && ua.tx_start) begin
            acks_a++;
            last_tx_cyc = cyc;
            chk("tx_start while busy", longint'(ua.tx_busy), 0);
            if (exp_ack_a.size() > 0) chk("ack data", ua.tx_data, exp_ack_a.pop_front());
            else chk("ack expected", 0, 1);
        end
        if (!rst && ub.tx_start) tx_b++;
    end

    typedef struct {
        int          d;
        logic [7:0]  b0, b1, b2;
        logic [39:0] bits;
        logic [7:0]  ack;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(int d, logic [7:0] b);
        if (d == 0) begin ua.rx_valid = 1'b1; ua.rx_data = b; end
        else        begin ub.rx_valid = 1'b1; ub.rx_data = b; end
        tick();
        ua.rx_valid = 1'b0;
        ub.rx_valid = 1'b0;
    endtask

    task automatic wait_frames(int d, int target, int budget);
        while (frames[d] < target && budget > 0) begin
            tick();
            budget--;
        end
        chk("frames seen", frames[d], target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c0, d0, a0, f0, rel;
        vecs[0] = '{0, 8'h02, 8'hA5, 8'h00, 40'h02A5, 8'h02};
        vecs[1] = '{0, 8'hFF, 8'h00, 8'h00, 40'hFF00, 8'hFF};
        vecs[2] = '{0, 8'h80, 8'h01, 8'h00, 40'h8001, 8'h80};
        vecs[3] = '{0, 8'h5A, 8'hC3, 8'h00, 40'h5AC3, 8'h5A};
        vecs[4] = '{1, 8'hF9, 8'h12, 8'h34, 40'h91234, 8'h00};
        vecs[5] = '{1, 8'h3C, 8'hFF, 8'h01, 40'hCFF01, 8'h00};

        rst = 1'b1;
        ua.rx_valid = 1'b0; ua.rx_data = '0; ua.tx_busy = 1'b0;
        ub.rx_valid = 1'b0; ub.rx_data = '0; ub.tx_busy = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("reset serial_out a", longint'(so_a), 1);
        chk("reset serial_out b", longint'(so_b), 1);
        chk("reset frame_busy a", longint'(fb_a), 0);
        chk("reset drop_err a", longint'(de_a), 0);
        chk("reset tx_start a", longint'(ua.tx_start), 0);
        chk("reset tx_data a", ua.tx_data, 0);

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            int d;
            d = vecs[i].d;
            if (d == 0) begin
                exp_frm_a.push_back(vecs[i].bits);
                exp_ack_a.push_back(vecs[i].ack);
            end else begin
                exp_frm_b.push_back(vecs[i].bits);
            end
            send(d, vecs[i].b0);
            c = cyc;
            send(d, vecs[i].b1);
            if (d == 1) begin
                c = cyc;
                send(d, vecs[i].b2);
            end else begin
                c = cyc - 1;
            end
            wait_frames(d, frames[d] + 1, 100);
            chk("start latency", start_cyc[d] - c, 2);
            tick(2);
            if (d == 0) begin
                chk("ack latency", last_tx_cyc - stop_cyc[0], 1);
                chk("frame_busy after a", longint'(fb_a), 0);
            end else begin
                chk("frame_busy after b", longint'(fb_b), 0);
            end
        end

        // Back-to-back lookahead
        exp_frm_a.push_back(40'h013C); exp_ack_a.push_back(8'h01);
        exp_frm_a.push_back(40'h03F0); exp_ack_a.push_back(8'h03);
        f0 = frames[0];
        send(0, 8'h01); send(0, 8'h3C);
        tick(4);
        send(0, 8'h03); send(0, 8'hF0);
        wait_frames(0, f0 + 2, 200);
        chk("b2b gap", gap[0], 3);
        tick(3);

        // Overflow: third frame's byte 0 while one shifts and one is held
        exp_frm_a.push_back(40'h1122); exp_ack_a.push_back(8'h11);
        exp_frm_a.push_back(40'h3344); exp_ack_a.push_back(8'h33);
        f0 = frames[0];
        d0 = drops[0];
        send(0, 8'h11); send(0, 8'h22);
        tick(2);
        send(0, 8'h33); send(0, 8'h44);
        tick(2);
        c = cyc;
        send(0, 8'h77);
        wait_frames(0, f0 + 2, 200);
        chk("overflow drops", drops[0] - d0, 1);
        chk("overflow drop cycle", drop_cyc[0], c);
        tick(3);
        chk("overflow idle", longint'(fb_a), 0);

        // Timeout with a lone byte
        f0 = frames[0];
        d0 = drops[0];
        c0 = cyc;
        send(0, 8'h05);
        tick(20);
        chk("timeout drops", drops[0] - d0, 1);
        chk("timeout cycle", drop_cyc[0] - c0, 16);
        chk("timeout no frame", frames[0], f0);
        chk("timeout idle", longint'(fb_a), 0);
        exp_frm_a.push_back(40'h0611); exp_ack_a.push_back(8'h06);
        send(0, 8'h06); send(0, 8'h11);
        wait_frames(0, f0 + 1, 100);
        tick(3);

        // Byte arriving in the expiry cycle starts a new frame
        f0 = frames[0];
        d0 = drops[0];
        send(0, 8'h05);
        tick(15);
        exp_frm_a.push_back(40'h0733); exp_ack_a.push_back(8'h07);
        send(0, 8'h07); send(0, 8'h33);
        wait_frames(0, f0 + 1, 100);
        chk("expiry-cycle drops", drops[0] - d0, 1);
        tick(3);

        // ACK backpressure
        a0 = acks_a;
        f0 = frames[0];
        ua.tx_busy = 1'b1;
        exp_frm_a.push_back(40'h4299); exp_ack_a.push_back(8'h42);
        send(0, 8'h42); send(0, 8'h99);
        wait_frames(0, f0 + 1, 100);
        tick(50);
        chk("busy held no ack", acks_a - a0, 0);
        chk("busy held frame_busy", longint'(fb_a), 1);
        rel = cyc;
        ua.tx_busy = 1'b0;
        tick(4);
        chk("backpressure ack count", acks_a - a0, 1);
        chk("backpressure ack cycle", last_tx_cyc, rel);

        // Reset mid-frame truncates without ACK
        send(0, 8'hAB); send(0, 8'hCD);
        tick(8);
        a0 = acks_a;
        f0 = frames[0];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset serial_out", longint'(so_a), 1);
        chk("midreset frame_busy", longint'(fb_a), 0);
        chk("midreset tx_data", ua.tx_data, 0);
        tick(40);
        chk("midreset no ack", acks_a, a0);
        chk("midreset no frame", frames[0], f0);

        // Leftovers
        chk("frame a queue drained", exp_frm_a.size(), 0);
        chk("frame b queue drained", exp_frm_b.size(), 0);
        chk("ack queue drained", exp_ack_a.size(), 0);
        chk("b tx_start never", tx_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/serial_frame_master.md
SERIAL_FRAME_MASTER -- requirements
Module: serial_frame_master

Interface
REQ-001 Parameter ADDR_W, default 8, node address bits per frame, range 1..8.
REQ-002 Parameter DATA_BYTES, default 1, payload bytes per frame, range 1..4.
REQ-003 Parameter TIMEOUT, default 65535, idle cycles allowed between bytes of one frame, range 2..65535.
REQ-004 Parameter ACK_EN, default 1, 1 = echo the address byte to UART after each frame.
REQ-005 clk  input  1  sole clock, all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 rx_valid  input  1  one-cycle strobe, byte received by UART.
REQ-008 rx_data  input  8  received byte, valid with rx_valid.
REQ-009 tx_busy  input  1  UART transmitter busy.
REQ-010 tx_start  output  1  one-cycle strobe requesting UART transmit.
REQ-011 tx_data  output  8  byte to transmit, stable while tx_start is high.
REQ-012 serial_out  output  1  shared serial bus to percept nodes, idles high.
REQ-013 frame_busy  output  1  high while any frame is assembling, pending or shifting.
REQ-014 drop_err  output  1  one-cycle pulse when a byte or partial frame is discarded.

Function
REQ-015 Assembly: byte 0 of a frame supplies the address (rx_data[ADDR_W-1:0], upper bits ignored); bytes 1..DATA_BYTES supply the payload, with the first payload byte most significant.
REQ-016 After byte DATA_BYTES is captured, the assembly register is marked full; while full, any rx_valid byte is dropped, drop_err pulses, and the byte count is unchanged.
REQ-017 Shifter states: IDLE, START, ADDR, DATA, STOP, ACK.
REQ-018 IDLE: serial_out=1; if full, load address/payload into the shift register, clear full, go to START in the same cycle.
- A byte arriving in that same cycle is accepted as byte 0 of the next frame.
REQ-019 START: serial_out=0 for exactly 1 cycle.
REQ-020 ADDR: address MSB first, 1 bit per cycle, ADDR_W cycles.
REQ-021 DATA: payload MSB first, 1 bit per cycle, 8*DATA_BYTES cycles.
REQ-022 STOP: serial_out=1 for 1 cycle, then go to ACK if ACK_EN=1, else IDLE.
REQ-023 Total frame on serial_out: 2+ADDR_W+8*DATA_BYTES cycles, first bit driven the cycle after the load.
REQ-024 ACK: serial_out=1; wait while tx_busy=1; on the first cycle with tx_busy=0, pulse tx_start for one cycle with tx_data = the frame address zero-extended to 8 bits, then go to IDLE.
REQ-025 Assembly continues in parallel with shifting and ACK, giving a one-frame lookahead buffer.
REQ-026 Timeout counter:
- Cleared on every accepted byte.
- Increments while 0 < byte count and not full.
- On reaching TIMEOUT: the partial frame is discarded, byte count returns to 0, and drop_err pulses.
REQ-027 A byte arriving in the same cycle the timeout expires is taken as byte 0 of a new frame.
REQ-028 frame_busy = (state != IDLE) or full or (byte count != 0).
REQ-029 tx_start is never asserted outside ACK, and never while tx_busy=1.

Reset
REQ-030 rst=1 at a rising edge forces:
- state IDLE, serial_out=1
- byte count 0, full=0, timeout counter 0
- tx_start=0, tx_data=0x00, drop_err=0, frame_busy=0
REQ-031 A reset mid-frame truncates the frame: serial_out=1 from the next cycle, and no ACK is sent.

Verification (defaults unless stated)
REQ-032 Single frame:
- Stimulus: rx bytes 0x02, 0xA5, tx_busy=0.
- Response: serial_out = 0, 00000010, 10100101, 1 (18 cycles), then tx_start with tx_data=0x02, then frame_busy=0.
REQ-033 Back-to-back lookahead:
- Stimulus: frame (0x01,0x3C), then frame (0x03,0xF0) fully received during the first shift.
- Response: the second frame starts in the cycle after the first returns to IDLE, with no gap bits and both ACKs in order.
REQ-034 Overflow:
- Stimulus: a third frame's byte 0 arrives while one frame is shifting and one is full.
- Response: drop_err pulses once and the two held frames are transmitted unchanged.
REQ-035 Timeout:
- Stimulus: TIMEOUT=16, byte 0x05 only.
- Response: drop_err pulses 16 cycles after the byte, no frame is shifted, and the next bytes 0x06, 0x11 form a clean frame.
REQ-036 ACK backpressure:
- Stimulus: tx_busy held high for 50 cycles after STOP.
- Response: tx_start is delayed until the first cycle with tx_busy=0, exactly one pulse.
REQ-037 Parameter sweep:
- Stimulus: ADDR_W=4, DATA_BYTES=2, ACK_EN=0, bytes 0xF9, 0x12, 0x34.
- Response: serial_out = 0, 1001, 0001001000110100, 1 (22 cycles), with tx_start never asserted.
